muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Parametrised iterative multiply/divide unit that produces a double-width {hi, lo} result for the execute stage's HILO path. It performs signed or unsigned shift-add multiplication and restoring division at one bit per cycle, with a start/done handshake. It adds behaviour the single-cycle ALU path does not have: pipeline-flush abort, divide-by-zero reporting, and back-to-back issue. It sits beside the ALU and feeds HILO writeback and the execute-stage stall logic.

## Interface
- WIDTH, 32, operand width; results are 2*WIDTH bits as {hi, lo}
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only in IDLE or DONE
- op_div  in  1  0 = multiply, 1 = divide; sampled with start
- sign  in  1  1 = signed (two's complement) operands; sampled with start
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- flush  in  1  abort current operation (exception/branch flush)
- busy  out  1  high in CALC and FIX; drives the stage stall
- done  out  1  one-cycle pulse; hi/lo valid in this cycle and held afterwards
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient
- div_zero  out  1  registered; set with done when a divide had b == 0, cleared on the next accepted start

## Operation
- States: IDLE, CALC, FIX, DONE. Reset: state IDLE, busy 0, done 0, hi 0, lo 0, div_zero 0, iteration counter 0.
- Accept (start & ~flush in IDLE or DONE):
  - latch op_div and sign;
  - latch |a| and |b| when sign=1, raw a and b when sign=0;
  - latch result-negate flags;
  - counter := 0; go to CALC.
- Divide with b == 0: skip to DONE. hi := a (raw), lo := all ones, div_zero := 1.
- CALC: one iteration per cycle. Go to FIX when counter reaches WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. Remainder register is WIDTH+1 bits so the trial subtract never loses the borrow.
- FIX (one cycle):
  - Multiply: negate the 2*WIDTH product if sign and a[MSB]^b[MSB].
  - Divide: negate the quotient if sign and signs differ; negate the remainder if sign and a[MSB]=1.
  - Write hi/lo; go to DONE.
- DONE: done=1 for exactly this cycle. Next state is CALC if a new start is accepted, otherwise IDLE.
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH per half.
  - Signed most-negative / -1 yields lo = 2^(WIDTH-1) (wraps) and hi = 0.
  - The remainder always has the sign of the dividend (or is zero).
- start during CALC/FIX is ignored. The requester must hold start until busy rises, or re-issue it.
- hi/lo change only in FIX or in the divide-by-zero transition. They are stable at all other times, including after a flush.

## Timing
- start accepted in cycle 0 → CALC in cycles 1..WIDTH → FIX in cycle WIDTH+1 → done in cycle WIDTH+2 (34 for WIDTH=32).
- busy is high in cycles 1..WIDTH+1. busy is low in DONE, so the stall releases in the done cycle.
- Divide-by-zero: start in cycle 0 → done and div_zero in cycle 1. busy stays 0.
- Back-to-back: start asserted in a DONE cycle is accepted there. The next done follows WIDTH+2 cycles later.
- Flush priority, highest first: rst, flush, start.
  - flush in any cycle → IDLE next cycle.
  - No done is generated for an aborted operation, and hi/lo/div_zero keep their prior values.
  - flush together with start in IDLE: start is dropped.
  - flush during DONE: done still pulses in that cycle; state goes to IDLE.
- rst mid-operation: IDLE next cycle, and every output takes its reset value.

## Test plan
- Signed multiply, a=0xFFFFFFFD (-3), b=5, start at cycle 0 → done only in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy high in cycles 1–33.
- Unsigned multiply, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; then an immediate start in the DONE cycle with a=7, b=6 → next done 34 cycles later with hi=0, lo=42.
- Signed divide, -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, no hang.
- Unsigned divide, 100/0 → done and div_zero in cycle 1, hi=100, lo=0xFFFFFFFF. The next valid start clears div_zero in cycle 1.
- Flush in cycle 10 of a multiply (prior hi/lo = 0x1/0x2) → busy low in cycle 11, no done within 40 cycles, hi/lo stay 0x1/0x2.
- rst asserted in cycle 20 of a divide → all outputs 0 in the next cycle. Then start 9/4 unsigned → lo=2, hi=1.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the execute-stage HILO path.
// Signed/unsigned shift-add multiply and restoring divide, one bit per cycle,
// with flush abort, divide-by-zero reporting and back-to-back issue from DONE.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               op_div_r;
    logic               neg_lo;     // negate product / quotient in FIX
    logic               neg_hi;     // negate remainder in FIX
    logic [WIDTH-1:0]   opa;        // |multiplicand|
    logic [WIDTH-1:0]   opb;        // |divisor|
    logic [2*WIDTH-1:0] acc;        // multiply accumulator {partial, multiplier}
    logic [WIDTH:0]     rem;        // partial remainder, one spare bit
    logic [WIDTH-1:0]   quot;       // dividend shifting out, quotient shifting in

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy   = (state == CALC) || (state == FIX);
    assign done   = (state == DONE);
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign abs_a  = (sign && a[WIDTH-1]) ? -a : a;
    assign abs_b  = (sign && b[WIDTH-1]) ? -b : b;

    // One multiply/divide iteration step and the FIX-stage sign correction.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        mul_sum  = '0;
        div_diff = '0;
        div_ge   = 1'b0;
        prod_fix = acc;
        quot_fix = quot;
        rem_fix  = rem[WIDTH-1:0];

        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
        // Borrow out of the top bit means the shifted remainder is below the divisor.
        div_diff = {rem, quot[WIDTH-1]} - {2'b00, opb};
        div_ge   = ~div_diff[WIDTH+1];

        if (neg_lo) begin
            prod_fix = -acc;
            quot_fix = -quot;
        end
        if (neg_hi) begin
            rem_fix = -rem[WIDTH-1:0];
        end
    end

    // Control FSM and datapath registers; priority rst > flush > start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_div_r <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            rem      <= '0;
            quot     <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_div_r <= op_div;
                        opa      <= abs_a;
                        opb      <= abs_b;
                        acc      <= {{WIDTH{1'b0}}, abs_b};
                        rem      <= '0;
                        quot     <= abs_a;
                        neg_lo   <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi   <= sign && a[WIDTH-1];
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        if (op_div && (b == '0)) begin
                            hi       <= a;
                            lo       <= '1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (op_div_r) begin
                        rem  <= div_ge ? div_diff[WIDTH:0] : {rem[WIDTH-1:0], quot[WIDTH-1]};
                        quot <= {quot[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_div_r) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: the stimulus pushes expected {hi, lo, div_zero}
// per issued operation; a monitor pops and compares on every done pulse.
module tb_muldiv_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_div;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        string        nm;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_div   (op_div),
        .sign     (sign),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.nm, " hi:lo"}, {hi, lo}, {e.hi, e.lo});
                check({e.nm, " div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
            end
        end
    end

    // Issue one operation at a negedge and return at the negedge of its done cycle.
    task automatic run_op(input string nm, input logic op, input logic sg,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edz, input int lat);
        int cyc;
        int busy_err;
        start  = 1'b1;
        op_div = op;
        sign   = sg;
        a      = av;
        b      = bv;
        sb.push_back('{eh, el, edz, nm});
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_err = 0;
        check({nm, " div_zero cycle1"}, {63'd0, div_zero}, {63'd0, (lat == 1)});
        while (cyc <= 60) begin
            if (done) break;
            if (busy !== (cyc <= W + 1)) busy_err++;
            @(negedge clk);
            cyc++;
        end
        if (busy !== 1'b0) busy_err++;
        check({nm, " latency"}, 64'(cyc), 64'(lat));
        check({nm, " busy profile errors"}, 64'(busy_err), 64'd0);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; op_div = 1'b0; sign = 1'b0;
        a = '0; b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset outputs", {29'd0, busy, done, div_zero, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);

        // Signed multiply -3 * 5.
        run_op("smul -3*5", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, W + 2);
        @(negedge clk);

        // Unsigned max*max, then back-to-back issue from the DONE cycle.
        run_op("umul max*max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, W + 2);
        run_op("umul 7*6 b2b", 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, W + 2);
        @(negedge clk);

        // Signed divides, including the overflow case.
        run_op("sdiv -7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W + 2);
        run_op("sdiv 7/-2", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, W + 2);
        run_op("sdiv min/-1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, W + 2);
        @(negedge clk);

        // Divide by zero, then a valid divide that must clear div_zero.
        run_op("udiv 100/0", 1'b1, 1'b0, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1);
        @(negedge clk);
        run_op("udiv 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W + 2);
        run_op("sdiv -5/0", 1'b1, 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1);
        @(negedge clk);

        // Establish hi/lo = 0x1/0x2, then flush a multiply in cycle 10.
        run_op("umul 0x80000001*2", 1'b0, 1'b0, 32'h80000001, 32'd2, 32'd1, 32'd2, 1'b0, W + 2);
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; sign = 1'b0; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy before flush", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("busy after flush", {63'd0, busy}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("done after flush", 64'(ndone), 64'd0);
        check("hi:lo kept after flush", {hi, lo}, {32'd1, 32'd2});

        // flush together with start in IDLE drops the start.
        start = 1'b1; op_div = 1'b0; a = 32'd3; b = 32'd3; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", {62'd0, busy, done}, 64'd0);
        repeat (3) @(negedge clk);

        // rst in cycle 20 of a divide clears everything.
        start = 1'b1; op_div = 1'b1; sign = 1'b0; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("busy before rst", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid-op outputs", {29'd0, busy, done, div_zero, hi}, 64'd0);
        check("rst mid-op lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op("udiv 9/4 after rst", 1'b1, 1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, W + 2);
        repeat (2) @(negedge clk);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
